btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 3: number of push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): consecutive clk cycles a new input level must persist before it is accepted; legal range is at least 1.
REQ-003 clk  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 btn_n  input  N_BTN  raw board buttons, active-low, asynchronous to clk, bouncing.
REQ-006 btn_level  output  N_BTN  debounced button state, active-high (1 = held).
REQ-007 btn_clean_n  output  N_BTN  debounced button state, active-low; always equals ~btn_level; feeds the downstream lock FSM btn input directly.
REQ-008 btn_press  output  N_BTN  one-cycle pulse per accepted press (debounced 0->1 of btn_level).
REQ-009 btn_release  output  N_BTN  one-cycle pulse per accepted release (debounced 1->0 of btn_level).
REQ-010 any_press  output  1  OR of btn_press.

Function
REQ-011 Each btn_n bit SHALL pass through a dedicated 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL hold an independent stable-state register and a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 Counter rule, per channel, every cycle: if synchronized level equals stable state, counter SHALL clear to 0; otherwise, if counter equals DEBOUNCE_CYCLES-1, stable state SHALL take the synchronized level and counter SHALL clear to 0; otherwise counter SHALL increment by 1.
REQ-014 Counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-015 Latency: with raw change held steady and the first rising edge that samples it numbered edge 1, stable state SHALL update at edge DEBOUNCE_CYCLES+2.
REQ-016 A raw change lasting fewer than DEBOUNCE_CYCLES consecutive synchronized cycles SHALL produce no output change; any bounce back SHALL restart the count from 0.
REQ-017 btn_level, btn_clean_n, btn_press, btn_release and any_press SHALL all be registered outputs.
REQ-018 btn_press[i] SHALL be 1 for exactly the one cycle in which btn_level[i] first reads 1, and btn_release[i] likewise when it first reads 0.
REQ-019 btn_press and btn_release of one channel SHALL never be high together.
REQ-020 Channels SHALL be fully independent; simultaneous acceptance on several channels SHALL pulse all their btn_press bits in the same cycle.
REQ-021 A button held indefinitely SHALL produce exactly one btn_press pulse; there SHALL be no auto-repeat.

Reset
REQ-022 While rstn=0: synchronizer flops SHALL be 1 (released); stable state, btn_level, btn_press, btn_release, any_press and counters SHALL be 0; btn_clean_n SHALL be all 1.
REQ-023 Reset asserted mid-debounce SHALL discard the pending count with no pulse; a button held through reset release SHALL be re-accepted as a fresh press after the REQ-015 latency.

Verification (DEBOUNCE_CYCLES=4, N_BTN=3)
REQ-024 Clean press: btn_n=110 from before edge 1, then held -> btn_level=001, btn_clean_n=110 and btn_press=001 after edge 6; btn_press=000 after edge 7; btn_level stays 001.
REQ-025 Glitch reject: btn_n[1] low for 3 cycles, then high -> btn_level, btn_press and btn_release stay 0 throughout.
REQ-026 Bounce: btn_n[2] pattern low 2, high 1, low held -> exactly one btn_press[2] pulse, 6 edges after the final falling sample.
REQ-027 Release: after an accepted press, btn_n[0] returns high and is held -> btn_release[0] pulses once 6 edges later; btn_level[0]=0.
REQ-028 Simultaneous: btn_n 111->000 at once, held -> btn_press=111 and any_press=1 in the same single cycle.
REQ-029 Reset mid-count: rstn pulsed low after 2 mismatch cycles while the button is held -> no pulse during reset; btn_press pulses once the REQ-015 latency after rstn rises.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Push-button conditioner bus: raw active-low buttons in, debounced level and edge pulses out.
interface btn_conditioner_if #(
  parameter int unsigned N_BTN = 3
);
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_clean_n;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;

  // Board / stimulus side: drives raw buttons, observes conditioned outputs.
  modport master (
    output btn_n,
    input  btn_level,
    input  btn_clean_n,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  // Conditioner side.
  modport slave (
    input  btn_n,
    output btn_level,
    output btn_clean_n,
    output btn_press,
    output btn_release,
    output any_press
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel synchronizer + debounce counter for bouncing active-low push buttons,
// producing a debounced level (both polarities) and one-cycle press/release pulses.
module btn_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rstn,
  btn_conditioner_if.slave   bus
);

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_n;
  logic [N_BTN-1:0] sync2_n;
  logic [N_BTN-1:0] sync_lvl;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_nxt;
  logic [N_BTN-1:0] press_nxt;
  logic [N_BTN-1:0] release_nxt;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];

  // Two-flop synchronizer per raw button; resets to the released level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= bus.btn_n;
      sync2_n <= sync1_n;
    end
  end

  assign sync_lvl = ~sync2_n;

  // Debounce rule: agreement clears the count; a full run of disagreement flips the stable state.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync_lvl[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = sync_lvl[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
    press_nxt   = stable_nxt & ~stable;
    release_nxt = ~stable_nxt & stable;
  end

  // Stable state and counters; reset drops any pending count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // The stable-state register is itself the debounced level output.
  assign bus.btn_level = stable;

  // Registered inverted level and edge pulses, aligned with the stable-state update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.btn_clean_n <= '1;
      bus.btn_press   <= '0;
      bus.btn_release <= '0;
      bus.any_press   <= 1'b0;
    end else begin
      bus.btn_clean_n <= ~stable_nxt;
      bus.btn_press   <= press_nxt;
      bus.btn_release <= release_nxt;
      bus.any_press   <= |press_nxt;
    end
  end

endmodule
